// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared NoC router port indices, select encoding and allocator states
package noc_pkg;

  localparam int PORT_N = 0;
  localparam int PORT_S = 1;
  localparam int PORT_E = 2;
  localparam int PORT_W = 3;
  localparam int PORT_L = 4;

  localparam logic [2:0] SEL_NONE = 3'b111;

  typedef enum logic {
    IDLE,
    LOCKED
  } alloc_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first set request at or after ptr
module rr_pick #(
  parameter int NPORTS = 5
) (
  input  logic [NPORTS-1:0] req,
  input  logic [2:0]        ptr,
  output logic [2:0]        winner,
  output logic              any
);

  int idx;

  // Scan from the farthest offset down so the nearest request to ptr is the last write.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    for (int k = NPORTS - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NPORTS;
      if (req[idx]) begin
        winner = 3'(idx);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/output_port_alloc.sv
// rtl/output_port_alloc.sv - per-output wormhole switch allocator with credit flow control
module output_port_alloc
  import noc_pkg::*;
#(
  parameter int NPORTS  = 5,
  parameter int CREDITS = 4,
  parameter int CW      = $clog2(CREDITS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NPORTS-1:0] req_i,
  input  logic [NPORTS-1:0] flit_valid_i,
  input  logic [NPORTS-1:0] tail_i,
  input  logic              credit_i,
  output logic [NPORTS-1:0] grant_o,
  output logic [2:0]        sel_o,
  output logic              flit_valid_o,
  output logic [CW-1:0]     credits_o,
  output logic              locked_o
);

  alloc_state_t  state, state_nxt;
  logic [2:0]    owner, owner_nxt;
  logic [2:0]    ptr, ptr_nxt;
  logic [CW-1:0] credits;
  logic          has_credit;
  logic [2:0]    pick_idx;
  logic          pick_any;

  assign has_credit = (credits != '0);

  rr_pick #(.NPORTS(NPORTS)) u_pick (
    .req    (req_i),
    .ptr    (ptr),
    .winner (pick_idx),
    .any    (pick_any)
  );

  // Pop is same-cycle with the grant; no credit bypass, only the registered count gates it.
  always_comb begin
    grant_o = '0;
    if (state == LOCKED && has_credit && flit_valid_i[owner]) begin
      grant_o[owner] = 1'b1;
    end
  end

  assign flit_valid_o = |grant_o;
  assign sel_o        = (state == LOCKED) ? owner : SEL_NONE;
  assign locked_o     = (state == LOCKED);
  assign credits_o    = credits;

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (pick_any && has_credit) begin
          state_nxt = LOCKED;
          owner_nxt = pick_idx;
        end
      end
      LOCKED: begin
        if (flit_valid_o && tail_i[owner]) begin
          state_nxt = IDLE;
          ptr_nxt   = (owner == 3'(NPORTS - 1)) ? 3'd0 : owner + 3'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Send and return in the same cycle cancel; a return at full depth is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits <= CW'(CREDITS);
    end else begin
      case ({flit_valid_o, credit_i})
        2'b10:   credits <= credits - CW'(1);
        2'b01:   if (credits != CW'(CREDITS)) credits <= credits + CW'(1);
        default: credits <= credits;
      endcase
    end
  end

endmodule

// File: tb/tb_output_port_alloc.sv
// tb/tb_output_port_alloc.sv - directed bench with a per-cycle reference model of the allocator
module tb_output_port_alloc;

  localparam int NP = 5;
  localparam int CR = 4;
  localparam int CW = $clog2(CR + 1);

  logic          clk;
  logic          rst;
  logic [NP-1:0] req_i;
  logic [NP-1:0] flit_valid_i;
  logic [NP-1:0] tail_i;
  logic          credit_i;
  logic [NP-1:0] grant_o;
  logic [2:0]    sel_o;
  logic          flit_valid_o;
  logic [CW-1:0] credits_o;
  logic          locked_o;

  int checks = 0;
  int errors = 0;

  output_port_alloc #(.NPORTS(NP), .CREDITS(CR)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req_i),
    .flit_valid_i (flit_valid_i),
    .tail_i       (tail_i),
    .credit_i     (credit_i),
    .grant_o      (grant_o),
    .sel_o        (sel_o),
    .flit_valid_o (flit_valid_o),
    .credits_o    (credits_o),
    .locked_o     (locked_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: packet ownership, rotating priority and a credit count as plain integers.
  int  m_locked = 0;
  int  m_owner  = 0;
  int  m_ptr    = 0;
  int  m_cred   = CR;

  initial begin
    forever begin
      int eg;
      int sent;
      @(negedge clk);
      if (rst) begin
        m_locked = 0; m_owner = 0; m_ptr = 0; m_cred = CR;
        chk("model_rst_grant", int'(grant_o), 0);
        chk("model_rst_sel", int'(sel_o), 7);
        chk("model_rst_credits", int'(credits_o), CR);
        chk("model_rst_locked", int'(locked_o), 0);
      end else begin
        eg = 0;
        if (m_locked != 0 && m_cred > 0 && flit_valid_i[m_owner]) eg = 1 << m_owner;
        sent = (eg != 0) ? 1 : 0;
        chk("model_grant", int'(grant_o), eg);
        chk("model_fvo", int'(flit_valid_o), sent);
        chk("model_sel", int'(sel_o), (m_locked != 0) ? m_owner : 7);
        chk("model_credits", int'(credits_o), m_cred);
        chk("model_locked", int'(locked_o), m_locked);
        if (m_locked != 0) begin
          if (sent != 0 && tail_i[m_owner]) begin
            m_locked = 0;
            m_ptr = (m_owner + 1) % NP;
          end
        end else if (m_cred > 0) begin
          for (int k = NP - 1; k >= 0; k--) begin
            if (req_i[(m_ptr + k) % NP]) begin
              m_owner = (m_ptr + k) % NP;
              m_locked = 1;
            end
          end
        end
        m_cred = m_cred - sent + (credit_i ? 1 : 0);
        if (m_cred > CR) m_cred = CR;
      end
    end
  end

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_grant"}, int'(grant_o), 0);
    chk({nm, "_sel"}, int'(sel_o), 7);
    chk({nm, "_credits"}, int'(credits_o), CR);
    chk({nm, "_locked"}, int'(locked_o), 0);
    chk({nm, "_fvo"}, int'(flit_valid_o), 0);
  endtask

  task automatic zero_inputs();
    req_i = '0; flit_valid_i = '0; tail_i = '0; credit_i = 1'b0;
  endtask

  task automatic do_reset(input string nm);
    @(posedge clk); #3;
    rst = 1'b1;
    zero_inputs();
    #1;
    chk_reset_outputs(nm);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One directed cycle: drive inputs after the edge, then check hand-computed outputs.
  task automatic vec(input string nm, input logic [4:0] rq, input logic [4:0] fv,
                     input logic [4:0] tl, input logic cr, input logic [4:0] eg,
                     input int es, input int ec, input int el);
    @(posedge clk); #1;
    req_i = rq; flit_valid_i = fv; tail_i = tl; credit_i = cr;
    #1;
    chk({nm, "_grant"}, int'(grant_o), int'(eg));
    chk({nm, "_fvo"}, int'(flit_valid_o), int'(|eg));
    chk({nm, "_sel"}, int'(sel_o), es);
    chk({nm, "_credits"}, int'(credits_o), ec);
    chk({nm, "_locked"}, int'(locked_o), el);
  endtask

  initial begin
    rst = 1'b1;
    zero_inputs();
    #2;
    chk_reset_outputs("por");
    @(posedge clk); #1;
    rst = 1'b0;

    // Single-flit packet from L, then ptr wraps to N
    vec("l0", 5'b10000, 5'b10000, 5'b10000, 0, 5'b00000, 7, 4, 0);
    vec("l1", 5'b10000, 5'b10000, 5'b10000, 0, 5'b10000, 4, 4, 1);
    vec("l2", 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 7, 3, 0);
    vec("l3", 5'b00011, 5'b00011, 5'b00011, 0, 5'b00000, 7, 3, 0);
    vec("l4", 5'b00011, 5'b00011, 5'b00011, 0, 5'b00001, 0, 3, 1);
    vec("l5", 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 7, 2, 0);

    // Round-robin between N and E with credits returned every cycle
    do_reset("rst_rr");
    vec("rr0", 5'b00101, 5'b00101, 5'b00101, 1, 5'b00000, 7, 4, 0);
    vec("rr1", 5'b00101, 5'b00101, 5'b00101, 1, 5'b00001, 0, 4, 1);
    vec("rr2", 5'b00101, 5'b00101, 5'b00101, 1, 5'b00000, 7, 4, 0);
    vec("rr3", 5'b00101, 5'b00101, 5'b00101, 1, 5'b00100, 2, 4, 1);
    vec("rr4", 5'b00101, 5'b00101, 5'b00101, 1, 5'b00000, 7, 4, 0);
    vec("rr5", 5'b00101, 5'b00101, 5'b00101, 1, 5'b00001, 0, 4, 1);
    vec("rr6", 5'b00101, 5'b00101, 5'b00101, 1, 5'b00000, 7, 4, 0);
    vec("rr7", 5'b00101, 5'b00101, 5'b00101, 1, 5'b00100, 2, 4, 1);

    // Wormhole: 4-flit S packet holds the path while W waits
    do_reset("rst_wh");
    vec("wh0", 5'b01010, 5'b01010, 5'b01000, 1, 5'b00000, 7, 4, 0);
    vec("wh1", 5'b01010, 5'b01010, 5'b01000, 1, 5'b00010, 1, 4, 1);
    vec("wh2", 5'b01000, 5'b01010, 5'b01000, 1, 5'b00010, 1, 4, 1);
    vec("wh3", 5'b01000, 5'b01010, 5'b01000, 1, 5'b00010, 1, 4, 1);
    vec("wh4", 5'b01000, 5'b01010, 5'b01010, 1, 5'b00010, 1, 4, 1);
    vec("wh5", 5'b01000, 5'b01000, 5'b01000, 1, 5'b00000, 7, 4, 0);
    vec("wh6", 5'b01000, 5'b01000, 5'b01000, 1, 5'b01000, 3, 4, 1);
    vec("wh7", 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 7, 4, 0);

    // Credit exhaustion on a 6-flit E packet
    do_reset("rst_ex");
    vec("ex0", 5'b00100, 5'b00100, 5'b00000, 0, 5'b00000, 7, 4, 0);
    vec("ex1", 5'b00100, 5'b00100, 5'b00000, 0, 5'b00100, 2, 4, 1);
    vec("ex2", 5'b00000, 5'b00100, 5'b00000, 0, 5'b00100, 2, 3, 1);
    vec("ex3", 5'b00000, 5'b00100, 5'b00000, 0, 5'b00100, 2, 2, 1);
    vec("ex4", 5'b00000, 5'b00100, 5'b00000, 0, 5'b00100, 2, 1, 1);
    vec("ex5", 5'b00000, 5'b00100, 5'b00000, 0, 5'b00000, 2, 0, 1);
    vec("ex6", 5'b00000, 5'b00100, 5'b00000, 1, 5'b00000, 2, 0, 1);
    vec("ex7", 5'b00000, 5'b00100, 5'b00000, 0, 5'b00100, 2, 1, 1);
    vec("ex8", 5'b00000, 5'b00100, 5'b00100, 0, 5'b00000, 2, 0, 1);
    vec("ex9", 5'b00000, 5'b00100, 5'b00100, 1, 5'b00000, 2, 0, 1);
    vec("ex10", 5'b00000, 5'b00100, 5'b00100, 0, 5'b00100, 2, 1, 1);
    vec("ex11", 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 7, 0, 0);

    // Simultaneous send and return, then saturation at full depth
    do_reset("rst_cs");
    vec("cs0", 5'b10000, 5'b10000, 5'b00000, 0, 5'b00000, 7, 4, 0);
    vec("cs1", 5'b10000, 5'b10000, 5'b00000, 0, 5'b10000, 4, 4, 1);
    vec("cs2", 5'b00000, 5'b10000, 5'b00000, 0, 5'b10000, 4, 3, 1);
    vec("cs3", 5'b00000, 5'b10000, 5'b00000, 1, 5'b10000, 4, 2, 1);
    vec("cs4", 5'b00000, 5'b10000, 5'b10000, 0, 5'b10000, 4, 2, 1);
    vec("cs5", 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 7, 1, 0);
    vec("cs6", 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 7, 2, 0);
    vec("cs7", 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 7, 3, 0);
    vec("cs8", 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 7, 4, 0);
    vec("cs9", 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 7, 4, 0);

    // Reset in the middle of a 3-flit N packet
    do_reset("rst_mp0");
    vec("mp0", 5'b00001, 5'b00001, 5'b00000, 0, 5'b00000, 7, 4, 0);
    vec("mp1", 5'b00001, 5'b00001, 5'b00000, 0, 5'b00001, 0, 4, 1);
    vec("mp2", 5'b00000, 5'b00001, 5'b00000, 0, 5'b00001, 0, 3, 1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("mid_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    zero_inputs();
    vec("mp3", 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 7, 4, 0);
    vec("mp4", 5'b00010, 5'b00010, 5'b00010, 0, 5'b00000, 7, 4, 0);
    vec("mp5", 5'b00010, 5'b00010, 5'b00010, 0, 5'b00010, 1, 4, 1);

    @(posedge clk); #1;
    zero_inputs();
    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
